// File: rtl/data_memory_lsu.sv
// RV32I data memory with byte/half/word load-store sizing and a sticky fault capture register.
// Optional DMEM_PERF_CNT_EN adds LoadCount/StoreCount performance counters.
module data_memory_lsu #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [2:0]  Funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   input  logic        FaultClear,
   output logic [31:0] ReadData,
   output logic        AccessFault,
   output logic        FaultValid,
   output logic [31:0] FaultAddr
`ifdef DMEM_PERF_CNT_EN
   ,
   output logic [31:0] LoadCount,
   output logic [31:0] StoreCount
`endif
);
   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic [31:0]   word_rd;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   ld_val;
   logic          size_bad, misalign, oor, store_ok;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic          fv_q, fv_d;
   logic [31:0]   fa_q, fa_d;

   assign idx = Addr[AW+1:2];

   // Stores may not use the unsigned load encodings; 011/11x are never legal.
   assign size_bad = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11) || (MemWrite && Funct3[2]);
   assign misalign = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                     ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
   assign oor      = |Addr[31:AW+2];
   assign AccessFault = (MemRead || MemWrite) && (size_bad || misalign || oor);
   assign store_ok    = MemWrite && !AccessFault;

   assign word_rd  = mem_q[idx];
   assign byte_sel = word_rd[8*Addr[1:0] +: 8];
   assign half_sel = Addr[1] ? word_rd[31:16] : word_rd[15:0];

   always_comb begin
      ld_val = '0;
      case (Funct3)
         3'b000:  ld_val = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ld_val = {24'b0, byte_sel};
         3'b001:  ld_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  ld_val = {16'b0, half_sel};
         3'b010:  ld_val = word_rd;
         default: ld_val = '0;
      endcase
   end

   assign ReadData = (MemRead && !AccessFault) ? ld_val : '0;

   always_comb begin
      be    = 4'b0000;
      wdata = WriteData;
      case (Funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << Addr[1:0];
            wdata = {4{WriteData[7:0]}};
         end
         2'b01: begin
            be    = Addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WriteData[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else if (store_ok) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   // A new fault outranks a simultaneous clear, so capture is checked first.
   always_comb begin
      fv_d = fv_q;
      fa_d = fa_q;
      if (AccessFault && (!fv_q || FaultClear)) begin
         fv_d = 1'b1;
         fa_d = Addr;
      end else if (FaultClear) begin
         fv_d = 1'b0;
         fa_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fv_q <= 1'b0;
         fa_q <= '0;
      end else begin
         fv_q <= fv_d;
         fa_q <= fa_d;
      end
   end

   assign FaultValid = fv_q;
   assign FaultAddr  = fa_q;

`ifdef DMEM_PERF_CNT_EN
   logic        ld_inc;
   logic [31:0] lc_q, lc_d, sc_q, sc_d;

   assign ld_inc = MemRead && !AccessFault;

   always_comb begin
      lc_d = FaultClear ? 32'd0 : lc_q;
      sc_d = FaultClear ? 32'd0 : sc_q;
      if (ld_inc)   lc_d = FaultClear ? 32'd1 : lc_q + 32'd1;
      if (store_ok) sc_d = FaultClear ? 32'd1 : sc_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lc_q <= '0;
         sc_q <= '0;
      end else begin
         lc_q <= lc_d;
         sc_q <= sc_d;
      end
   end

   assign LoadCount  = lc_q;
   assign StoreCount = sc_q;
`endif
endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: byte-addressed reference model, expectations queued at issue,
// checked by an independent monitor on the falling edge.
module tb_data_memory_lsu;
   localparam int DEPTH = 256;
   localparam int NBYTES = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemWrite = 1'b0, MemRead = 1'b0, FaultClear = 1'b0;
   logic [2:0]  Funct3 = 3'b010;
   logic [31:0] Addr = '0, WriteData = '0;
   logic [31:0] ReadData, FaultAddr;
   logic        AccessFault, FaultValid;
`ifdef DMEM_PERF_CNT_EN
   logic [31:0] LoadCount, StoreCount;
`endif

   data_memory_lsu #(.DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .MemRead(MemRead),
      .Funct3(Funct3), .Addr(Addr), .WriteData(WriteData), .FaultClear(FaultClear),
      .ReadData(ReadData), .AccessFault(AccessFault), .FaultValid(FaultValid),
      .FaultAddr(FaultAddr)
`ifdef DMEM_PERF_CNT_EN
      , .LoadCount(LoadCount), .StoreCount(StoreCount)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        af;
      logic        fv;
      logic [31:0] fa;
      logic [31:0] lc;
      logic [31:0] sc;
   } exp_t;

   exp_t        sb_q[$];
   logic [7:0]  mem_m [NBYTES];
   logic        fv_m;
   logic [31:0] fa_m, lc_m, sc_m;
   int          n_chk = 0, n_fail = 0;

   function automatic bit is_fault(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
      int sz;
      if (!(rd || wr)) return 1'b0;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (wr && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if ((a % sz) != 0) return 1'b1;
      if (longint'(a) >= longint'(NBYTES)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] load_val(logic [2:0] f3, logic [31:0] a);
      logic [31:0] w;
      case (f3)
         3'd0: w = {{24{mem_m[a][7]}}, mem_m[a]};
         3'd4: w = {24'd0, mem_m[a]};
         3'd1: w = {{16{mem_m[a+1][7]}}, mem_m[a+1], mem_m[a]};
         3'd5: w = {16'd0, mem_m[a+1], mem_m[a]};
         default: w = {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
      endcase
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
      fv_m = 1'b0; fa_m = '0; lc_m = '0; sc_m = '0;
   endtask

   // Drives one cycle of inputs just after the rising edge, queues what the monitor
   // must see before the next edge, then advances the model past that edge.
   task automatic op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input bit fc, input bit rst_v = 1'b1);
      exp_t e;
      bit   f;
      int   sz;
      @(posedge clk); #1;
      rst_n = rst_v; MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a;
      WriteData = wd; FaultClear = fc;
      if (!rst_v) model_reset();
      f    = is_fault(rd, wr, f3, a);
      e.rd = (rd && !f) ? load_val(f3, a) : 32'd0;
      e.af = f;
      e.fv = fv_m; e.fa = fa_m; e.lc = lc_m; e.sc = sc_m;
      sb_q.push_back(e);
      if (rst_v) begin
         if (wr && !f) begin
            sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            for (int i = 0; i < sz; i++) mem_m[a + i] = wd[8*i +: 8];
         end
         if (f && (!fv_m || fc)) begin fv_m = 1'b1; fa_m = a; end
         else if (fc) begin fv_m = 1'b0; fa_m = '0; end
         if (rd && !f) lc_m = fc ? 32'd1 : lc_m + 32'd1;
         else if (fc)  lc_m = '0;
         if (wr && !f) sc_m = fc ? 32'd1 : sc_m + 32'd1;
         else if (fc)  sc_m = '0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ReadData", ReadData, e.rd);
            chk("AccessFault", {31'd0, AccessFault}, {31'd0, e.af});
            chk("FaultValid", {31'd0, FaultValid}, {31'd0, e.fv});
            chk("FaultAddr", FaultAddr, e.fa);
`ifdef DMEM_PERF_CNT_EN
            chk("LoadCount", LoadCount, e.lc);
            chk("StoreCount", StoreCount, e.sc);
`endif
         end
      end
   end

   initial begin : stim
      logic [31:0] a;
      logic [2:0]  f3;
      model_reset();
      repeat (2) @(posedge clk);
      op(1, 0, 3'd2, 32'h10, 0, 0);                 // reset state, rst_n released
      op(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
      op(1, 0, 3'd2, 32'h10, 0, 0);
      op(0, 1, 3'd0, 32'h21, 32'h00000080, 0);
      op(1, 0, 3'd2, 32'h20, 0, 0);
      op(1, 0, 3'd0, 32'h21, 0, 0);
      op(1, 0, 3'd4, 32'h21, 0, 0);
      op(0, 1, 3'd1, 32'h32, 32'h00008001, 0);
      op(1, 0, 3'd1, 32'h32, 0, 0);
      op(1, 0, 3'd5, 32'h32, 0, 0);
      op(1, 0, 3'd2, 32'h30, 0, 0);
      op(0, 1, 3'd2, 32'h42, 32'hCAFEF00D, 0);      // misaligned store
      op(1, 0, 3'd2, 32'h40, 0, 0);
      op(1, 0, 3'd1, 32'h45, 0, 0);                 // second fault keeps 0x42
      op(0, 0, 3'd2, 32'h0, 0, 1);
      op(1, 0, 3'd2, 32'h400, 0, 0);                // out of range
      op(0, 1, 3'd2, 32'h3FC, 32'h12345678, 0);
      op(1, 0, 3'd2, 32'h3FC, 0, 0);
      op(1, 1, 3'd2, 32'h10, 32'h0BADF00D, 0);      // read-during-write sees old word
      op(1, 0, 3'd2, 32'h10, 0, 0);
      op(0, 1, 3'd4, 32'h50, 32'h11, 1);            // illegal store size, clear loses to set
      op(0, 0, 3'd2, 32'h0, 0, 0);
      op(1, 0, 3'd7, 32'h0, 0, 1);
      op(0, 0, 3'd2, 32'h0, 0, 1);
      for (int n = 0; n < 600; n++) begin
         a  = $urandom_range(0, 32'h40F);
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, a, $urandom,
            $urandom_range(0, 15) == 0);
      end
      op(0, 1, 3'd2, 32'h3FC, 32'hA5A5A5A5, 0);
      op(0, 1, 3'd2, 32'h10, 32'h5A5A5A5A, 0);
      op(0, 1, 3'd2, 32'h2, 32'h1, 0);              // leave FaultValid set
      op(1, 0, 3'd2, 32'h10, 0, 0, 1'b0);           // reset falls mid-cycle
      op(1, 0, 3'd2, 32'h3FC, 0, 0, 1'b0);
      op(0, 1, 3'd2, 32'h20, 32'hFFFFFFFF, 0, 1'b0); // store during reset discarded
      op(1, 0, 3'd2, 32'h20, 0, 0, 1'b1);
      op(1, 0, 3'd2, 32'h20, 0, 0);
      op(0, 0, 3'd2, 32'h0, 0, 0);
      for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Data memory with load/store sizing logic.
- Sits directly downstream of the ALU: ALUResult is the byte address, and the rs2 value is the store data.
- Performs RV32I byte/half/word loads and stores with sign/zero extension.
- Includes a sticky fault capture register for misaligned, out-of-range or illegal-size accesses.
- Combinational read and synchronous write, as a single-cycle core requires.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, from 4 to 65536.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- MemWrite  input  1  store request this cycle
- MemRead  input  1  load request this cycle
- Funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- Addr  input  32  byte address (ALUResult)
- WriteData  input  32  store data, right-aligned
- FaultClear  input  1  synchronous clear of the fault register
- ReadData  output  32  extended load result
- AccessFault  output  1  combinational; current access is faulty
- FaultValid  output  1  sticky fault flag
- FaultAddr  output  32  address of the first captured fault

Behaviour:
- **Clock and reset:** one clock domain. Reset is asynchronous and active-low: rst_n low immediately clears every memory word to 0, FaultValid to 0 and FaultAddr to 0. Hence ReadData resets to 0.
- **Word index:** Addr[log2(DEPTH_WORDS)+1:2]; byte lane is Addr[1:0].
- **Faulty access:** (MemRead or MemWrite) AND any of the following:
  - Funct3 in {011, 110, 111};
  - Funct3 in {011, 110, 111} for a store, or Funct3 in {100, 101} for a store;
  - half access (001/101) with Addr[0]=1;
  - word access with Addr[1:0]!=00;
  - Addr >= 4*DEPTH_WORDS.
  AccessFault reflects this combinationally.
- **Loads (combinational, zero latency):**
  - ReadData = 0 when MemRead=0 or the access is faulty.
  - lb/lbu select byte lane Addr[1:0]; lh/lhu select half Addr[1]; lw returns the whole word.
  - b/h sign-extend bit 7/15; bu/hu zero-extend.
- **Stores (rising edge, MemWrite=1 and not faulty):**
  - sb writes WriteData[7:0] into lane Addr[1:0].
  - sh writes WriteData[15:0] into half Addr[1].
  - sw writes the full word.
  - Other bytes of the word are unchanged.
  - A faulty store writes nothing.
- **Read-during-write, same address:** ReadData shows the pre-edge contents; the new data is visible after the edge.
- **MemRead and MemWrite both high:** the store executes and ReadData returns the old data.
- **Fault register (rising edge):**
  - If AccessFault and FaultValid=0: FaultValid<=1 and FaultAddr<=Addr.
  - Further faults while FaultValid=1 do not overwrite FaultAddr.
  - FaultClear=1 clears FaultValid and FaultAddr to 0.
  - When FaultClear and a new fault occur in the same cycle, the new fault is captured (set wins; FaultAddr takes the new Addr).
- **Reset mid-operation:** a store whose edge coincides with rst_n low is discarded.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- **Defined:** adds outputs LoadCount[31:0] and StoreCount[31:0], reset to 0.
  - LoadCount increments on each edge with MemRead=1 and no fault.
  - StoreCount increments on each edge with a committed store.
  - Both wrap from 0xFFFFFFFF to 0.
  - Both are cleared by FaultClear only when FaultClear and no increment occur together; otherwise the increment wins from 0, giving a value of 1.
- **Undefined:** the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- **Word store/load:** sw 0xDEADBEEF at Addr 0x10, then lw 0x10 -> ReadData 0xDEADBEEF, AccessFault 0.
- **Byte lanes:** sb 0x80 at 0x21 on a zeroed word, then lw 0x20 -> 0x00008000; lb 0x21 -> 0xFFFFFF80; lbu 0x21 -> 0x00000080.
- **Halfwords:** sh 0x8001 at 0x32, then lh 0x32 -> 0xFFFF8001; lhu 0x32 -> 0x00008001; lw 0x30 -> 0x80010000.
- **Misaligned store:**
  - sw at 0x42 -> AccessFault 1, memory unchanged, FaultValid 1, FaultAddr 0x42.
  - A following lh at 0x45 keeps FaultAddr 0x42.
  - FaultClear -> FaultValid 0.
- **Out of range, DEPTH_WORDS=256:**
  - lw 0x400 -> ReadData 0, AccessFault 1.
  - sw 0x3FC 0x12345678, then lw 0x3FC -> 0x12345678.
- **Async reset:**
  - rst_n low mid-cycle after stores -> lw of all written addresses returns 0 and FaultValid is 0 without waiting for a clock edge.
  - With DMEM_PERF_CNT_EN, 3 loads and 2 stores -> LoadCount 3, StoreCount 2.
